// File: rtl/fault_recovery_ctrl_mc_if.sv
// Bundle between control unit, datapath and the fault recovery controller.
// The controller uses the slave modport; the control/datapath side (or a
// bench) uses the master modport. Clock and reset stay plain ports.
// Handshake note: there is no valid/ready pair here. All inputs are level
// signals sampled on every rising clock edge; all outputs are combinational
// from registered controller state plus the *_normal enables.
interface fault_recovery_ctrl_mc_if #(
   parameter int N_SRC = 4,
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
);
   logic [N_SRC-1:0] fault_vec;
   logic             retire_valid;
   logic             clear_halt;
   logic [XLEN-1:0]  pc_current;
   logic             pc_write_normal;
   logic             reg_write_normal;
   logic             mem_write_normal;
   logic             pc_write_out;
   logic             reg_write_out;
   logic             mem_write_out;
   logic [XLEN-1:0]  pc_next;
   logic             pc_override;
   logic             insert_nop;
   logic             retry_en;
   logic [1:0]       fault_state;
   logic [N_SRC-1:0] fault_src;
   logic [3:0]       retry_count;
   logic [CNT_W-1:0] fault_count;
   logic             wdt_fault;

   modport slave (
      input  fault_vec, retire_valid, clear_halt, pc_current,
             pc_write_normal, reg_write_normal, mem_write_normal,
      output pc_write_out, reg_write_out, mem_write_out, pc_next,
             pc_override, insert_nop, retry_en, fault_state, fault_src,
             retry_count, fault_count, wdt_fault
   );

   modport master (
      output fault_vec, retire_valid, clear_halt, pc_current,
             pc_write_normal, reg_write_normal, mem_write_normal,
      input  pc_write_out, reg_write_out, mem_write_out, pc_next,
             pc_override, insert_nop, retry_en, fault_state, fault_src,
             retry_count, fault_count, wdt_fault
   );
endinterface

// File: rtl/fault_recovery_ctrl_mc.sv
// Multi-source fault recovery controller: freeze / rollback-retry / halt.
// Gates PC/register/memory write enables, keeps a rollback PC checkpoint
// and exports saturating fault statistics.
// Optional feature macro: FTC_WATCHDOG_EN (retire watchdog, minor fault).
module fault_recovery_ctrl_mc #(
   parameter int               N_SRC         = 4,
   parameter logic [N_SRC-1:0] CRIT_MASK     = 4'b1000,
   parameter int               XLEN          = 32,
   parameter logic [XLEN-1:0]  RESET_PC      = 32'h0000_0000,
   parameter int               MAX_RETRY     = 2,
   parameter int               FREEZE_CYCLES = 2,
   parameter int               CNT_W         = 8,
   parameter int               WDT_CYCLES    = 64
) (
   input  logic                          clk,
   input  logic                          reset_n,
   fault_recovery_ctrl_mc_if.slave       ftc
);

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_FREEZE  = 2'd1,
      S_RECOVER = 2'd2,
      S_HALT    = 2'd3
   } state_e;

   localparam int FW = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;

   state_e           state_q,    state_d;
   logic [XLEN-1:0]  pc_saved_q, pc_saved_d;
   logic [N_SRC-1:0] src_q,      src_d;
   logic [3:0]       retry_q,    retry_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [FW-1:0]    frz_q,      frz_d;

   logic any_fault;
   logic crit;
   logic wdt_hit;

   assign any_fault = |ftc.fault_vec;
   assign crit      = |(ftc.fault_vec & CRIT_MASK);

`ifdef FTC_WATCHDOG_EN
   localparam int WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   logic [WW-1:0] wdt_q, wdt_d;

   assign wdt_hit = (state_q == S_RUN) && (wdt_q == WW'(WDT_CYCLES - 1));

   // Watchdog counts RUN cycles without a retire; clears on retire or exit.
   always_comb begin
      wdt_d = wdt_q + 1'b1;
      if (state_q != S_RUN || state_d != S_RUN || ftc.retire_valid)
         wdt_d = '0;
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wdt_q <= '0;
      else          wdt_q <= wdt_d;
   end
`else
   logic unused_wdt_cfg;
   assign unused_wdt_cfg = ^(32'(WDT_CYCLES));
   assign wdt_hit        = 1'b0;
`endif

   // Next-state and bookkeeping for the recovery FSM.
   always_comb begin
      state_d    = state_q;
      pc_saved_d = pc_saved_q;
      src_d      = src_q;
      retry_d    = retry_q;
      cnt_d      = cnt_q;
      frz_d      = frz_q;
      case (state_q)
         S_RUN: begin
            if (any_fault || wdt_hit) begin
               // A real fault outranks the watchdog and a same-cycle retire.
               if (any_fault) src_d = ftc.fault_vec;
               if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
               if ((any_fault && crit) || retry_q == 4'(MAX_RETRY)) begin
                  state_d = S_HALT;
               end else begin
                  state_d = S_FREEZE;
                  frz_d   = FW'(FREEZE_CYCLES - 1);
               end
            end else if (ftc.retire_valid) begin
               pc_saved_d = ftc.pc_current;
               retry_d    = '0;
            end
         end
         S_FREEZE: begin
            src_d = src_q | ftc.fault_vec;
            if (crit) begin
               state_d = S_HALT;
            end else if (frz_q == '0) begin
               state_d = S_RECOVER;
            end else begin
               frz_d = frz_q - 1'b1;
            end
         end
         S_RECOVER: begin
            // Faults seen during the rollback cycle are deliberately ignored.
            retry_d = retry_q + 1'b1;
            state_d = S_RUN;
         end
         S_HALT: begin
            if (ftc.clear_halt) begin
               state_d = S_RUN;
               retry_d = '0;
               src_d   = '0;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // State, checkpoint and statistics registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_RUN;
         pc_saved_q <= RESET_PC;
         src_q      <= '0;
         retry_q    <= '0;
         cnt_q      <= '0;
         frz_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_saved_q <= pc_saved_d;
         src_q      <= src_d;
         retry_q    <= retry_d;
         cnt_q      <= cnt_d;
         frz_q      <= frz_d;
      end
   end

   // Write gating and recovery control outputs from registered state.
   always_comb begin
      ftc.pc_write_out  = 1'b0;
      ftc.reg_write_out = 1'b0;
      ftc.mem_write_out = 1'b0;
      ftc.pc_override   = 1'b0;
      ftc.insert_nop    = 1'b0;
      ftc.retry_en      = 1'b0;
      case (state_q)
         S_RUN: begin
            ftc.pc_write_out  = ftc.pc_write_normal;
            ftc.reg_write_out = ftc.reg_write_normal;
            ftc.mem_write_out = ftc.mem_write_normal;
         end
         S_RECOVER: begin
            ftc.pc_write_out = 1'b1;
            ftc.pc_override  = 1'b1;
            ftc.insert_nop   = 1'b1;
            ftc.retry_en     = 1'b1;
         end
         default: ftc.insert_nop = 1'b1;
      endcase
      // Nothing may be written while reset is asserted.
      if (!reset_n) begin
         ftc.pc_write_out  = 1'b0;
         ftc.reg_write_out = 1'b0;
         ftc.mem_write_out = 1'b0;
         ftc.pc_override   = 1'b0;
         ftc.insert_nop    = 1'b0;
         ftc.retry_en      = 1'b0;
      end
   end

   assign ftc.pc_next     = pc_saved_q;
   assign ftc.fault_state = state_q;
   assign ftc.fault_src   = src_q;
   assign ftc.retry_count = retry_q;
   assign ftc.fault_count = cnt_q;
   assign ftc.wdt_fault   = wdt_hit & reset_n;

endmodule

// File: tb/tb_fault_recovery_ctrl_mc.sv
// Directed bench for fault_recovery_ctrl_mc. Built with FTC_WATCHDOG_EN the
// DUT uses WDT_CYCLES=8 and the watchdog path is exercised; otherwise the
// bench confirms the watchdog stays silent.
module tb_fault_recovery_ctrl_mc;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   fault_recovery_ctrl_mc_if #(.N_SRC(4), .XLEN(32), .CNT_W(8)) bus ();

   fault_recovery_ctrl_mc #(
      .N_SRC(4), .CRIT_MASK(4'b1000), .XLEN(32), .RESET_PC(32'h0),
      .MAX_RETRY(2), .FREEZE_CYCLES(2), .CNT_W(8), .WDT_CYCLES(8)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ftc     (bus.slave)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fault_pulse(input logic [3:0] f);
      bus.fault_vec = f;
      tick();
      bus.fault_vec = 4'b0000;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset_n              = 1'b0;
      bus.fault_vec        = 4'b0000;
      bus.retire_valid     = 1'b0;
      bus.clear_halt       = 1'b0;
      bus.pc_current       = 32'h0;
      bus.pc_write_normal  = 1'b1;
      bus.reg_write_normal = 1'b1;
      bus.mem_write_normal = 1'b1;
      #12;
      // Reset state
      chk("rst_pc_wr",  bus.pc_write_out, 0);
      chk("rst_reg_wr", bus.reg_write_out, 0);
      chk("rst_mem_wr", bus.mem_write_out, 0);
      chk("rst_nop",    bus.insert_nop, 0);
      chk("rst_pcnext", bus.pc_next, 32'h0);
      chk("rst_state",  bus.fault_state, 0);
      chk("rst_count",  bus.fault_count, 0);
      chk("rst_wdt",    bus.wdt_fault, 0);

      // Release, clean retire at 0x100
      @(negedge clk);
      reset_n          = 1'b1;
      bus.retire_valid = 1'b1;
      bus.pc_current   = 32'h100;
      #1;
      chk("run_pc_wr",  bus.pc_write_out, 1);
      chk("run_reg_wr", bus.reg_write_out, 1);
      chk("run_mem_wr", bus.mem_write_out, 1);
      chk("run_state",  bus.fault_state, 0);
      tick();
      bus.retire_valid = 1'b0;
      chk("ckpt_100", bus.pc_next, 32'h100);

      // Minor fault -> FREEZE x2 -> RECOVER -> RUN
      fault_pulse(4'b0001);
      chk("frz1_state", bus.fault_state, 1);
      chk("frz1_reg",   bus.reg_write_out, 0);
      chk("frz1_pc",    bus.pc_write_out, 0);
      chk("frz1_nop",   bus.insert_nop, 1);
      chk("frz1_src",   bus.fault_src, 4'b0001);
      chk("frz1_cnt",   bus.fault_count, 1);
      tick();
      chk("frz2_state", bus.fault_state, 1);
      tick();
      chk("rec_state",  bus.fault_state, 2);
      chk("rec_pcnext", bus.pc_next, 32'h100);
      chk("rec_ovr",    bus.pc_override, 1);
      chk("rec_retry",  bus.retry_en, 1);
      chk("rec_pcwr",   bus.pc_write_out, 1);
      chk("rec_regwr",  bus.reg_write_out, 0);
      tick();
      chk("run1_state", bus.fault_state, 0);
      chk("run1_rcnt",  bus.retry_count, 1);
      chk("run1_fcnt",  bus.fault_count, 1);
      chk("run1_ovr",   bus.pc_override, 0);

      // Second minor fault consumes the last retry; third escalates
      fault_pulse(4'b0100);
      tick();
      tick();
      tick();
      chk("run2_rcnt", bus.retry_count, 2);
      chk("run2_fcnt", bus.fault_count, 2);
      fault_pulse(4'b0010);
      chk("halt_state", bus.fault_state, 3);
      chk("halt_cnt",   bus.fault_count, 3);
      chk("halt_src",   bus.fault_src, 4'b0010);
      chk("halt_nop",   bus.insert_nop, 1);
      chk("halt_memwr", bus.mem_write_out, 0);
      tick();
      chk("halt_hold", bus.fault_state, 3);
      bus.clear_halt = 1'b1;
      tick();
      bus.clear_halt = 1'b0;
      chk("clr_state", bus.fault_state, 0);
      chk("clr_rcnt",  bus.retry_count, 0);
      chk("clr_src",   bus.fault_src, 0);
      chk("clr_fcnt",  bus.fault_count, 3);
      chk("clr_ckpt",  bus.pc_next, 32'h100);

      // Fault and retire in the same cycle: no checkpoint update
      bus.fault_vec    = 4'b0010;
      bus.retire_valid = 1'b1;
      bus.pc_current   = 32'h200;
      tick();
      bus.fault_vec    = 4'b0000;
      bus.retire_valid = 1'b0;
      chk("same_state", bus.fault_state, 1);
      chk("same_ckpt",  bus.pc_next, 32'h100);
      chk("same_fcnt",  bus.fault_count, 4);
      tick();
      tick();
      chk("same_rec",    bus.fault_state, 2);
      chk("same_pcnext", bus.pc_next, 32'h100);
      tick();
      chk("same_rcnt", bus.retry_count, 1);

      // Clean retire clears retry budget; critical fault in RUN
      bus.retire_valid = 1'b1;
      bus.pc_current   = 32'h300;
      tick();
      bus.retire_valid = 1'b0;
      chk("ck300_pc",   bus.pc_next, 32'h300);
      chk("ck300_rcnt", bus.retry_count, 0);
      fault_pulse(4'b1000);
      chk("crit_state", bus.fault_state, 3);
      chk("crit_src",   bus.fault_src, 4'b1000);
      chk("crit_fcnt",  bus.fault_count, 5);
      bus.clear_halt = 1'b1;
      tick();
      bus.clear_halt = 1'b0;
      chk("crit_clr", bus.fault_state, 0);

      // Critical fault during FREEZE
      fault_pulse(4'b0001);
      chk("fc_frz", bus.fault_state, 1);
      fault_pulse(4'b1000);
      chk("fc_state", bus.fault_state, 3);
      chk("fc_src",   bus.fault_src, 4'b1001);
      chk("fc_fcnt",  bus.fault_count, 6);
      chk("fc_ckpt",  bus.pc_next, 32'h300);
      bus.clear_halt = 1'b1;
      tick();
      bus.clear_halt = 1'b0;
      chk("fc_clr", bus.fault_state, 0);

`ifdef FTC_WATCHDOG_EN
      // Eighth RUN cycle without retire fires the watchdog
      repeat (6) tick();
      chk("wdt_quiet", bus.wdt_fault, 0);
      tick();
      chk("wdt_pulse", bus.wdt_fault, 1);
      chk("wdt_run",   bus.fault_state, 0);
      tick();
      chk("wdt_frz",   bus.fault_state, 1);
      chk("wdt_fcnt",  bus.fault_count, 7);
      chk("wdt_src",   bus.fault_src, 0);
      chk("wdt_off",   bus.wdt_fault, 0);
`else
      // No watchdog: long idle stays in RUN with wdt_fault low
      for (int i = 0; i < 80; i++) begin
         tick();
         chk("nowdt_flag",  bus.wdt_fault, 0);
         chk("nowdt_state", bus.fault_state, 0);
      end
      chk("nowdt_fcnt", bus.fault_count, 6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fault_recovery_ctrl_mc.md
Name: fault_recovery_ctrl_mc

Overview:
Multi-source successor to the single-fault recovery controller.
- Accepts a parametrised vector of fault sources and classifies each as minor or critical via a parameter mask.
- Runs a freeze / rollback-retry / halt state machine with a bounded retry budget and a rollback-PC checkpoint.
- Gates PC, register and memory write enables between the control unit and the datapath, and exports saturating fault statistics.

Parameters:
- N_SRC, 4, number of fault source inputs
- CRIT_MASK, 4'b1000, bit i = 1 marks fault_vec[i] as critical (width N_SRC)
- XLEN, 32, PC width
- RESET_PC, 32'h0000_0000, checkpoint PC value after reset
- MAX_RETRY, 2, retries allowed before a minor fault escalates to halt (1..15)
- FREEZE_CYCLES, 2, cycles spent in FREEZE before rollback (>=1)
- CNT_W, 8, width of saturating fault_count
- WDT_CYCLES, 64, watchdog timeout in cycles (used only with FTC_WATCHDOG_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- fault_vec  in  N_SRC  per-source fault flags, level, sampled each cycle
- retire_valid  in  1  an instruction committed this cycle
- clear_halt  in  1  external acknowledge that releases HALT
- pc_current  in  XLEN  PC of the committing instruction
- pc_write_normal  in  1  PC write enable from the control unit
- reg_write_normal  in  1  register write enable from the control unit
- mem_write_normal  in  1  memory write enable from the control unit
- pc_write_out  out  1  gated PC write enable
- reg_write_out  out  1  gated register write enable
- mem_write_out  out  1  gated memory write enable
- pc_next  out  XLEN  rollback PC target
- pc_override  out  1  pc_next must be loaded this cycle
- insert_nop  out  1  squash / inject NOP
- retry_en  out  1  one-cycle retry pulse
- fault_state  out  2  0=RUN 1=FREEZE 2=RECOVER 3=HALT
- fault_src  out  N_SRC  sticky latched sources of the current episode
- retry_count  out  4  retries consumed
- fault_count  out  CNT_W  total fault episodes, saturating
- wdt_fault  out  1  watchdog timeout pulse

Behaviour:
- Reset (reset_n low, async): state RUN; pc_saved=RESET_PC; fault_src, retry_count, fault_count, freeze counter and watchdog counter all 0.
- Outputs during reset: all *_out = 0; pc_override, insert_nop, retry_en, wdt_fault = 0; pc_next=RESET_PC.
- Fault detection: any_fault = |fault_vec; crit = |(fault_vec & CRIT_MASK).
- RUN, write gating: *_out = *_normal.
- RUN, clean retire (retire_valid & !any_fault): pc_saved <= pc_current; retry_count <= 0.
- RUN, any_fault: fault_src <= fault_vec; fault_count increments, saturating at all-ones. Fault takes priority over a same-cycle retire, so no checkpoint and no retry clear that cycle.
  - crit, or retry_count == MAX_RETRY -> HALT.
  - otherwise -> FREEZE, freeze counter loaded with FREEZE_CYCLES-1.
- FREEZE: all *_out = 0; insert_nop = 1.
  - New faults are ORed into fault_src; no further count increment.
  - crit -> HALT immediately.
  - Otherwise the counter decrements; at 0 -> RECOVER.
  - Time in FREEZE is exactly FREEZE_CYCLES cycles.
- RECOVER (exactly 1 cycle): pc_override=1, pc_next=pc_saved, pc_write_out=1, reg/mem_write_out=0, insert_nop=1, retry_en=1.
  - retry_count increments.
  - Faults this cycle are ignored.
  - Next state RUN.
- HALT: all *_out = 0; insert_nop=1; stays in HALT while clear_halt is low.
  - clear_halt=1 -> RUN next cycle; retry_count and fault_src cleared; pc_saved unchanged.
  - fault_count is not cleared.
- pc_next = pc_saved in all states (qualified by pc_override).
- All outputs are combinational from registered state/counters plus the *_normal inputs only. fault_vec has one cycle of latency to state change.

Optional Feature:
FTC_WATCHDOG_EN
- Defined: a counter increments each RUN cycle without retire_valid and resets on retire_valid or on leaving RUN.
  - When it reaches WDT_CYCLES-1, wdt_fault pulses 1 cycle and is treated as a minor fault in that cycle: FREEZE path, fault_count increments, fault_src unchanged, and it counts against the retry budget.
  - A real fault in the same cycle takes precedence.
- Undefined: no watchdog logic; wdt_fault tied 0.

Test Plan:
- Reset release, RUN with retire_valid, pc_current=0x100, *_normal=1 -> *_out=1; a later rollback targets 0x100; fault_state=0.
- fault_vec=4'b0001 in RUN after checkpoint 0x100 -> FREEZE for 2 cycles with writes 0, then RECOVER with pc_next=0x100, pc_override=1, retry_en=1, then RUN; retry_count=1, fault_count=1.
- Three consecutive minor faults with no clean retire between them -> retries 1 and 2 recover; third fault goes to HALT (state 3). clear_halt=1 -> RUN, retry_count=0, fault_count=3.
- fault_vec=4'b1000 in RUN, and separately during FREEZE -> HALT next cycle in both cases; fault_src bit 3 set.
- fault_vec=4'b0010 with retire_valid=1, pc_current=0x200 in the same cycle -> checkpoint stays at the previous value; rollback pc_next = previous checkpoint.
- FTC_WATCHDOG_EN, WDT_CYCLES=8, no retire for 8 cycles -> wdt_fault pulses in cycle 8, FREEZE entered, fault_count+1. Without the macro -> wdt_fault stays 0 and state stays RUN.
